// File: rtl/note_tone_generator.sv
// Square-wave tone synthesiser: plays a note/octave for dur_ms, then a silent release gap, then pulses done.
// Output drives a 12-bit unsigned DAC centred on midscale.
module note_tone_generator #(
  parameter int unsigned MS_DIV = 100000,
  parameter int unsigned GAP_MS = 10,
  parameter logic [11:0] AMP    = 12'd1024
) (
  input  logic        CLOCK,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [3:0]  note,
  input  logic [2:0]  octave,
  input  logic [15:0] dur_ms,
  output logic        busy,
  output logic        done,
  output logic        tone,
  output logic [11:0] sample
);

  localparam logic [11:0] MID = 12'h800;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [3:0]  note_q;
  logic [18:0] hp_q;
  logic [18:0] pc;
  logic [16:0] ms_cnt;
  logic [15:0] remaining;

  logic        rest_q;
  logic        ms_tick;
  logic        last_ms;
  logic [2:0]  octave_clamped;
  logic [18:0] hp_calc;
  state_t      after_play;

  // Half-period in clock cycles for each note at the lowest octave row.
  function automatic logic [18:0] base_half_period(input logic [3:0] n);
    case (n)
      4'd0:    base_half_period = 19'd454545;
      4'd1:    base_half_period = 19'd429038;
      4'd2:    base_half_period = 19'd404959;
      4'd3:    base_half_period = 19'd382225;
      4'd4:    base_half_period = 19'd360776;
      4'd5:    base_half_period = 19'd340530;
      4'd6:    base_half_period = 19'd321409;
      4'd7:    base_half_period = 19'd303370;
      4'd8:    base_half_period = 19'd286344;
      4'd9:    base_half_period = 19'd270277;
      4'd10:   base_half_period = 19'd255102;
      4'd11:   base_half_period = 19'd240790;
      default: base_half_period = 19'd0;
    endcase
  endfunction

  assign octave_clamped = (octave == 3'd7) ? 3'd6 : octave;
  assign hp_calc        = base_half_period(note) >> octave_clamped;
  assign rest_q         = (note_q >= 4'd12);
  assign ms_tick        = (ms_cnt == 17'(MS_DIV - 1));
  assign last_ms        = ms_tick && (remaining == 16'd1);
  // A zero-length gap skips straight to the done pulse.
  assign after_play     = (GAP_MS == 0) ? FIN : GAP;

  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    busy       = 1'b1;
    done       = 1'b0;
    sample     = MID;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          next_state = (dur_ms != 16'd0) ? PLAY : after_play;
        end
      end
      PLAY: begin
        if (!rest_q) begin
          sample = tone ? (MID + AMP) : (MID - AMP);
        end
        if (stop) begin
          next_state = FIN;
        end else if (last_ms) begin
          next_state = after_play;
        end
      end
      GAP: begin
        if (stop || last_ms) begin
          next_state = FIN;
        end
      end
      FIN: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Shared ms counter/remaining pair times both the note and the release gap.
  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      note_q    <= 4'd0;
      hp_q      <= 19'd0;
      pc        <= 19'd0;
      ms_cnt    <= 17'd0;
      remaining <= 16'd0;
      tone      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            note_q    <= note;
            hp_q      <= hp_calc;
            pc        <= 19'd0;
            ms_cnt    <= 17'd0;
            remaining <= (dur_ms != 16'd0) ? dur_ms : 16'(GAP_MS);
            tone      <= (dur_ms != 16'd0) && (note < 4'd12);
          end
        end
        PLAY: begin
          if (next_state != PLAY) begin
            tone      <= 1'b0;
            pc        <= 19'd0;
            ms_cnt    <= 17'd0;
            remaining <= 16'(GAP_MS);
          end else begin
            ms_cnt <= ms_tick ? 17'd0 : ms_cnt + 17'd1;
            if (ms_tick) begin
              remaining <= remaining - 16'd1;
            end
            if (pc == hp_q - 19'd1) begin
              pc <= 19'd0;
              if (!rest_q) begin
                tone <= ~tone;
              end
            end else begin
              pc <= pc + 19'd1;
            end
          end
        end
        GAP: begin
          if (next_state != GAP) begin
            ms_cnt    <= 17'd0;
            remaining <= 16'd0;
          end else begin
            ms_cnt <= ms_tick ? 17'd0 : ms_cnt + 17'd1;
            if (ms_tick) begin
              remaining <= remaining - 16'd1;
            end
          end
        end
        default: begin
          tone <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_tone_generator.sv
// Bench for note_tone_generator: hand-derived vector table, hand-written reset sequence and
// randomized notes, all checked cycle by cycle against a timeline model of the note.
module tb_note_tone_generator;

  localparam int MS_DIV = 100;
  localparam int GAP_MS = 10;
  localparam int GAP_CYC = GAP_MS * MS_DIV;
  localparam logic [11:0] HI = 12'hC00;
  localparam logic [11:0] LO = 12'h400;
  localparam logic [11:0] MID = 12'h800;

  typedef struct {
    logic [3:0]  note;
    logic [2:0]  octave;
    logic [15:0] dur;
    int          hp;
    bit          rest;
    int          stop_at;
    int          restart_at;
    bit          stop_with_start;
  } vec_t;

  logic        CLOCK = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic [3:0]  note;
  logic [2:0]  octave;
  logic [15:0] dur_ms;
  logic        busy;
  logic        done;
  logic        tone;
  logic [11:0] sample;

  int compared = 0;
  int mismatched = 0;
  int rom[12] = '{454545, 429038, 404959, 382225, 360776, 340530,
                  321409, 303370, 286344, 270277, 255102, 240790};
  vec_t table_v[11];

  note_tone_generator #(.MS_DIV(MS_DIV), .GAP_MS(GAP_MS), .AMP(12'd1024)) dut (
    .CLOCK(CLOCK), .reset(reset), .start(start), .stop(stop), .note(note),
    .octave(octave), .dur_ms(dur_ms), .busy(busy), .done(done), .tone(tone),
    .sample(sample)
  );

  always #5 CLOCK = ~CLOCK;

  // Expected {busy, done, tone, sample} k cycles after the start edge.
  function automatic logic [14:0] expected(int k, int play, int hp, bit rest, int stop_at);
    logic t;
    if (stop_at > 0 && k == stop_at + 1) return {1'b1, 1'b1, 1'b0, MID};
    if (stop_at > 0 && k > stop_at + 1) return {1'b0, 1'b0, 1'b0, MID};
    if (k <= play) begin
      t = rest ? 1'b0 : (((k - 1) / hp) % 2 == 0);
      return {1'b1, 1'b0, t, rest ? MID : (t ? HI : LO)};
    end
    if (k <= play + GAP_CYC) return {1'b1, 1'b0, 1'b0, MID};
    if (k == play + GAP_CYC + 1) return {1'b1, 1'b1, 1'b0, MID};
    return {1'b0, 1'b0, 1'b0, MID};
  endfunction

  task automatic checkOutput(input string name, input int k, input logic [14:0] exp, output bit bad);
    logic [14:0] act;
    act = {busy, done, tone, sample};
    compared++;
    bad = (act !== exp);
    if (bad) begin
      mismatched++;
      $display("[TB] FAIL %s cycle %0d: got busy=%b done=%b tone=%b sample=%h, want busy=%b done=%b tone=%b sample=%h",
               name, k, act[14], act[13], act[12], act[11:0], exp[14], exp[13], exp[12], exp[11:0]);
    end
  endtask

  // Play one note from a start pulse through the return to IDLE, comparing every cycle.
  task automatic applyStimulus(input string name, input vec_t v);
    int  play;
    int  total;
    bit  bad;
    bit  hit;
    play  = int'(v.dur) * MS_DIV;
    total = (v.stop_at > 0) ? v.stop_at + 2 : play + GAP_CYC + 2;
    bad   = 1'b0;
    @(posedge CLOCK); #1;
    note   = v.note;
    octave = v.octave;
    dur_ms = v.dur;
    start  = 1'b1;
    stop   = v.stop_with_start;
    @(posedge CLOCK); #1;
    start  = 1'b0;
    stop   = 1'b0;
    note   = 4'($urandom);
    octave = 3'($urandom);
    dur_ms = 16'($urandom_range(1, 9));
    for (int k = 1; k <= total; k++) begin
      if (!bad) begin
        checkOutput(name, k, expected(k, play, v.hp, v.rest, v.stop_at), hit);
        bad = hit;
      end
      start = (k == v.restart_at);
      stop  = (k == v.stop_at);
      if (k < total) begin
        @(posedge CLOCK); #1;
      end
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    bit   hit;
    vec_t rv;
    int   oc;

    reset = 1'b1; start = 1'b0; stop = 1'b0;
    note = 4'd0; octave = 3'd0; dur_ms = 16'd0;
    #12;
    checkOutput("reset_state", 0, {3'b000, MID}, hit);
    @(negedge CLOCK);
    reset = 1'b0;

    table_v[0]  = '{4'd11, 3'd7, 16'd40, 3762, 1'b0, 0, 0, 1'b0};
    table_v[1]  = '{4'd7,  3'd6, 16'd50, 4740, 1'b0, 0, 0, 1'b0};
    table_v[2]  = '{4'd0,  3'd6, 16'd72, 7102, 1'b0, 0, 0, 1'b0};
    table_v[3]  = '{4'd13, 3'd3, 16'd10, 1,    1'b1, 0, 0, 1'b0};
    table_v[4]  = '{4'd3,  3'd4, 16'd0,  23889, 1'b0, 0, 0, 1'b0};
    table_v[5]  = '{4'd9,  3'd5, 16'd85, 8446, 1'b0, 0, 0, 1'b0};
    table_v[6]  = '{4'd11, 3'd6, 16'd60, 3762, 1'b0, 4500, 100, 1'b0};
    table_v[7]  = '{4'd0,  3'd6, 16'd20, 7102, 1'b0, 500, 200, 1'b0};
    table_v[8]  = '{4'd5,  3'd6, 16'd30, 5320, 1'b0, 0, 0, 1'b1};
    table_v[9]  = '{4'd2,  3'd6, 16'd5,  6327, 1'b0, 700, 0, 1'b0};
    table_v[10] = '{4'd15, 3'd0, 16'd3,  1,    1'b1, 0, 0, 1'b0};

    for (int i = 0; i < 11; i++) begin
      applyStimulus($sformatf("vec%0d", i), table_v[i]);
    end

    // Reset in the middle of a note returns to idle outputs without a done pulse.
    @(posedge CLOCK); #1;
    note = 4'd0; octave = 3'd6; dur_ms = 16'd10; start = 1'b1;
    @(posedge CLOCK); #1;
    start = 1'b0;
    repeat (300) @(posedge CLOCK);
    #3;
    checkOutput("mid_play_busy", 300, {1'b1, 1'b0, 1'b1, HI}, hit);
    reset = 1'b1;
    #1;
    checkOutput("async_reset", 0, {3'b000, MID}, hit);
    @(posedge CLOCK); #1;
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      checkOutput("post_reset_idle", k, {3'b000, MID}, hit);
      @(posedge CLOCK); #1;
    end

    // Randomized notes against the timeline model, half-period from the note table.
    for (int i = 0; i < 8; i++) begin
      rv.note   = 4'($urandom_range(0, 15));
      rv.octave = 3'($urandom_range(5, 7));
      rv.dur    = 16'($urandom_range(0, 25));
      oc        = (rv.octave == 3'd7) ? 6 : int'(rv.octave);
      rv.rest   = (rv.note >= 4'd12);
      rv.hp     = rv.rest ? 1 : (rom[rv.note] >> oc);
      rv.restart_at = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 50) : 0;
      rv.stop_with_start = 1'($urandom_range(0, 1));
      rv.stop_at = ($urandom_range(0, 3) == 0)
                 ? $urandom_range(rv.restart_at + 1, int'(rv.dur) * MS_DIV + GAP_CYC)
                 : 0;
      applyStimulus($sformatf("rand%0d", i), rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/note_tone_generator.md
Name: note_tone_generator

Overview:
- Reverse path of the frequency-to-note determiner: takes a note index in the same encoding and an octave, and synthesises a square-wave audio tone at that pitch.
- Plays the tone for a programmed duration in ms, then a short release gap, then pulses done.
- Sits between the tuner/playback control logic and the 12-bit audio DAC output stage.

Parameters:
- MS_DIV, 100000, clock cycles per 1 ms tick (100 MHz system clock); benches may reduce it.
- GAP_MS, 10, silent release gap in ms after each note.
- AMP, 12'd1024, square-wave half-amplitude around midscale.

Ports:
- CLOCK  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; samples note/octave/dur_ms when state is IDLE.
- stop  in  1  abort the current note.
- note  in  4  note index: A=0, A#=1, B=2, C=3 … G=10, G#=11; 15 = rest; 12–14 are treated as rest.
- octave  in  3  0 = A at 110 Hz row, up to 6; values of 7 are clamped to 6.
- dur_ms  in  16  play duration in ms.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the note (including its gap) completes or is aborted.
- tone  out  1  raw square wave.
- sample  out  12  unsigned DAC sample.

Behaviour:
- Reset (async, active-high): state=IDLE, busy=0, done=0, tone=0, sample=12'h800, all counters=0, latched registers=0.
- Half-period ROM, base values at octave 0 (cycles):
  - A 454545, A# 429038, B 404959, C 382225
  - C# 360776, D 340530, D# 321409, E 303370
  - F 286344, F# 270277, G 255102, G# 240790
  - Effective half-period hp = ROM[note] >> octave, 19 bits, truncating.
- States: IDLE, PLAY, GAP, FIN.
- IDLE:
  - start=1 latches note, clamped octave, dur_ms and hp.
  - Next state is PLAY if dur_ms≠0, otherwise GAP.
  - start while not IDLE is ignored; no queueing.
- PLAY:
  - Phase counter pc runs 0..hp-1. At pc==hp-1, tone toggles and pc clears.
  - tone=1 in the first PLAY cycle, i.e. one cycle after the start cycle.
  - Output sample: tone=1 → 12'h800+AMP, tone=0 → 12'h800-AMP.
  - Rest notes: tone is held at 0, sample=12'h800, and timing is unchanged.
  - ms counter runs 0..MS_DIV-1. On wrap, remaining ms decrements. When remaining reaches 0 → GAP.
  - PLAY therefore lasts exactly dur_ms*MS_DIV cycles.
- GAP: tone=0, sample=12'h800, lasts GAP_MS*MS_DIV cycles, then → FIN.
- FIN: done=1 for one cycle, then → IDLE. busy drops in the same cycle the state returns to IDLE.
- stop=1 in PLAY or GAP: next state is FIN, tone=0, sample=12'h800. stop in IDLE or FIN has no effect.
- Simultaneous start and stop in IDLE: start wins; stop is ignored that cycle.
- Reset mid-note: immediate return to reset values; no done pulse.
- Counter widths: pc 19 bits, ms counter 17 bits, remaining 16 bits. No overflow is possible within these ranges.

Test Plan:
- Reset: assert reset mid-PLAY → sample=12'h800, busy=0, tone=0 asynchronously; no done pulse.
- A, octave 2, dur_ms=2, MS_DIV=100000 (hp=113636):
  - tone rises 1 cycle after start and toggles every 113636 cycles (≈440 Hz).
  - PLAY spans 200000 cycles, then a 1000000-cycle gap.
  - done pulses exactly once, then busy=0.
- G#, octave 7 (clamped to 6), MS_DIV=20000, dur_ms=3:
  - hp=3762, sample alternates 12'h C00/12'h400.
  - 60000 play cycles.
- Rest (note=13), dur_ms=1, MS_DIV=1000: sample stays 12'h800 for 1000+GAP_MS*1000 cycles, then done.
- dur_ms=0: no PLAY cycles, GAP starts the cycle after start, done follows the gap.
- stop 500 cycles into PLAY: FIN on the next cycle, done pulses, and a start pulse issued mid-note earlier was ignored (busy high, latched note unchanged).
